mul_div_seq: RTL

//   Multi-cycle HI/LO arithmetic unit for the MIPS core: MULT/MULTU and, when enabled, DIV/DIVU.

---
 rtl/mul_div_seq.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mul_div_seq.sv
// rtl/mul_div_seq.sv - Multi-cycle HI/LO multiply (and divide when MULDIV_DIV_EN is defined) unit
// Radix-2 shift-add multiply / restoring divide over one shared 33-bit add per step.
module mul_div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t             state, state_nx;
    logic [5:0]         count;
    logic [WIDTH-1:0]   m_reg;      // multiplicand, or divisor
    logic [WIDTH-1:0]   acc;        // product high half, or partial remainder
    logic [WIDTH-1:0]   lq;         // multiplier shifting out, or quotient shifting in
    logic               neg_r;

    logic               sa, sb, op_legal;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH-1:0]   add_x, add_y;
    logic               add_cin;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH-1:0]   acc_step, lq_step;
    logic [2*WIDTH-1:0] prod, prod_fin;
    logic [WIDTH-1:0]   hi_fin, lo_fin;

`ifdef MULDIV_DIV_EN
    logic               is_div_r, sa_r, dzero_r;
    logic [WIDTH-1:0]   a_raw;
    logic [WIDTH:0]     rem_sh;
    logic               no_borrow;
    assign op_legal = 1'b1;
`else
    assign op_legal = ~op[1];
`endif

    assign sa    = op[0] & a[WIDTH-1];
    assign sb    = op[0] & b[WIDTH-1];
    assign mag_a = sa ? (~a + 1'b1) : a;
    assign mag_b = sb ? (~b + 1'b1) : b;

    assign add_sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start && op_legal) state_nx = S_RUN;
            S_RUN:   if (count == 6'd31) state_nx = S_FIN;
            S_FIN:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        add_x    = acc;
        add_y    = lq[0] ? m_reg : '0;
        add_cin  = 1'b0;
        acc_step = add_sum[WIDTH:1];
        lq_step  = {add_sum[0], lq[WIDTH-1:1]};
        prod     = {acc, lq};
        prod_fin = neg_r ? (~prod + 1'b1) : prod;
        hi_fin   = prod_fin[2*WIDTH-1:WIDTH];
        lo_fin   = prod_fin[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
        rem_sh    = {acc, lq[WIDTH-1]};
        no_borrow = 1'b0;
        if (is_div_r) begin
            add_x   = rem_sh[WIDTH-1:0];
            add_y   = ~m_reg;
            add_cin = 1'b1;
            // a set top bit of the shifted remainder means it already exceeds the divisor
            no_borrow = add_sum[WIDTH] | rem_sh[WIDTH];
            acc_step  = no_borrow ? add_sum[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            lq_step   = {lq[WIDTH-2:0], no_borrow};
            if (dzero_r) begin
                lo_fin = '1;
                hi_fin = a_raw;
            end else begin
                lo_fin = neg_r ? (~lq + 1'b1) : lq;
                hi_fin = sa_r ? (~acc + 1'b1) : acc;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            count <= '0;
            m_reg <= '0;
            acc   <= '0;
            lq    <= '0;
            neg_r <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
`ifdef MULDIV_DIV_EN
            is_div_r <= 1'b0;
            sa_r     <= 1'b0;
            dzero_r  <= 1'b0;
            a_raw    <= '0;
`endif
        end else begin
            state <= state_nx;
            done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start && op_legal) begin
                        busy  <= 1'b1;
                        count <= '0;
                        acc   <= '0;
                        neg_r <= sa ^ sb;
                        m_reg <= mag_a;
                        lq    <= mag_b;
`ifdef MULDIV_DIV_EN
                        is_div_r <= op[1];
                        sa_r     <= sa;
                        dzero_r  <= (b == '0);
                        a_raw    <= a;
                        if (op[1]) begin
                            m_reg <= mag_b;
                            lq    <= mag_a;
                        end
`endif
                    end
                end
                S_RUN: begin
                    acc   <= acc_step;
                    lq    <= lq_step;
                    count <= count + 6'd1;
                end
                S_FIN: begin
                    hi   <= hi_fin;
                    lo   <= lo_fin;
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
